// File: rtl/mmio_io_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mmio_io_pkg
// Purpose  : Register offsets, status bit positions and debounce defaults
//            for the memory-mapped I/O responder.
// Revision : 1.0
// ============================================================================
package mmio_io_pkg;

  localparam logic [1:0] ADDR_STATUS = 2'b00;
  localparam logic [1:0] ADDR_SWITCH = 2'b01;
  localparam logic [1:0] ADDR_LED    = 2'b10;
  localparam logic [1:0] ADDR_RSVD   = 2'b11;

  localparam int SW_READY_BIT  = 0;
  localparam int LED_READY_BIT = 1;

  localparam int          DEFAULT_CNT_W           = 16;
  localparam logic [15:0] DEFAULT_DEBOUNCE_CYCLES = 16'd50000;

  function automatic logic [31:0] status_word(input logic sw_ready, input logic led_ready);
    logic [31:0] w;
    w                = '0;
    w[SW_READY_BIT]  = sw_ready;
    w[LED_READY_BIT] = led_ready;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce
// Purpose  : Two-flop synchroniser plus stability counter; emits a one-cycle
//            press pulse on each accepted 0->1 transition.
// Revision : 1.0
// ============================================================================
module btn_debounce
  import mmio_io_pkg::*;
#(
  parameter int unsigned      CNT_W           = DEFAULT_CNT_W,
  parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = CNT_W'(DEFAULT_DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam logic [CNT_W-1:0] c_one      = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_terminal = DEBOUNCE_CYCLES - c_one;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;
  logic             w_differs;
  logic             w_flip;

  assign w_differs = (r_sync2 != r_level);
  assign w_flip    = w_differs && (r_cnt == c_terminal);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
      if (w_flip) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else if (w_differs) begin
        r_cnt <= r_cnt + c_one;
      end else begin
        r_cnt <= '0;
      end
    end
  end

  // Pulse is decoded in the cycle the flip is committed, so consumers see it
  // on the same edge that updates the accepted level.
  assign level = r_level;
  assign press = w_flip & r_sync2;

endmodule
`default_nettype wire

// File: rtl/mmio_io_responder.sv
`default_nettype none
// ============================================================================
// Module   : mmio_io_responder
// Purpose  : I/O-window register file: STATUS, latched SWITCH, gated LED.
// Revision : 1.0
// ============================================================================
module mmio_io_responder
  import mmio_io_pkg::*;
#(
  parameter int unsigned      CNT_W           = DEFAULT_CNT_W,
  parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = CNT_W'(DEFAULT_DEBOUNCE_CYCLES)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pRead,
  input  logic        pWrite,
  input  logic [1:0]  addr,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  input  logic        btnL,
  input  logic        btnR,
  input  logic [15:0] switch,
  output logic [11:0] led
);

  logic        w_btnl_level;
  logic        w_btnl_press;
  logic        w_btnr_level;
  logic        w_btnr_press;
  logic        w_sw_read;
  logic        w_led_write;
  logic        w_unused;
  logic [11:0] r_led;
  logic [15:0] r_sw_latch;
  logic        r_sw_ready;
  logic        r_led_ready;
  logic [31:0] w_rd_mux;

  btn_debounce #(
    .CNT_W           (CNT_W),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_deb_btnl (
    .clk   (clk),
    .reset (reset),
    .raw   (btnL),
    .level (w_btnl_level),
    .press (w_btnl_press)
  );

  btn_debounce #(
    .CNT_W           (CNT_W),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_deb_btnr (
    .clk   (clk),
    .reset (reset),
    .raw   (btnR),
    .level (w_btnr_level),
    .press (w_btnr_press)
  );

  assign w_sw_read   = pRead && !pWrite && (addr == ADDR_SWITCH);
  assign w_led_write = pWrite && (addr == ADDR_LED) && r_led_ready;
  assign w_unused    = ^{writeData[31:12], w_btnl_level, w_btnr_level};

  // A button event in the same cycle as the consuming access takes priority.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_led       <= '0;
      r_sw_latch  <= '0;
      r_sw_ready  <= 1'b0;
      r_led_ready <= 1'b0;
    end else begin
      if (w_btnr_press) begin
        r_sw_latch <= switch;
        r_sw_ready <= 1'b1;
      end else if (w_sw_read) begin
        r_sw_ready <= 1'b0;
      end

      if (w_led_write) begin
        r_led <= writeData[11:0];
      end

      if (w_btnl_press) begin
        r_led_ready <= 1'b1;
      end else if (w_led_write) begin
        r_led_ready <= 1'b0;
      end
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (addr)
      ADDR_STATUS: w_rd_mux = status_word(r_sw_ready, r_led_ready);
      ADDR_SWITCH: w_rd_mux = {16'b0, r_sw_latch};
      ADDR_LED:    w_rd_mux = {20'b0, r_led};
      default:     w_rd_mux = '0;
    endcase
  end

  assign readData = pRead ? w_rd_mux : 32'h0;
  assign led      = r_led;

endmodule
`default_nettype wire

// File: tb/tb_mmio_io_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmio_io_responder
// Purpose  : Self-checking bench for the MMIO I/O responder (debounce = 4).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_mmio_io_responder;
  import mmio_io_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        pRead;
  logic        pWrite;
  logic [1:0]  addr;
  logic [31:0] writeData;
  logic [31:0] readData;
  logic        btnL;
  logic        btnR;
  logic [15:0] switch;
  logic [11:0] led;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    string       name;
    logic        pread;
    logic        pwrite;
    logic [1:0]  a;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [11:0] exp_led;
  } vec_t;
  localparam int NVEC = 14;
  vec_t vecs[NVEC];

  always #5 clk = ~clk;

  mmio_io_responder #(
    .CNT_W           (16),
    .DEBOUNCE_CYCLES (16'd4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pRead     (pRead),
    .pWrite    (pWrite),
    .addr      (addr),
    .writeData (writeData),
    .readData  (readData),
    .btnL      (btnL),
    .btnR      (btnR),
    .switch    (switch),
    .led       (led)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change only on the falling edge; each tick ends any pending access.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    pRead  = 1'b0;
    pWrite = 1'b0;
  endtask

  task automatic drain_sb();
    sb_t e;
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.name, readData, e.exp);
    end
  endtask

  task automatic do_read(input string name, input logic [1:0] a, input logic [31:0] exp);
    pRead  = 1'b1;
    pWrite = 1'b0;
    addr   = a;
    sb_q.push_back('{name, exp});
    drain_sb();
  endtask

  task automatic set_vec(input int i, input string name, input logic pr, input logic pw,
                         input logic [1:0] a, input logic [31:0] wd,
                         input logic [31:0] rd, input logic [11:0] l);
    vecs[i] = '{name, pr, pw, a, wd, rd, l};
  endtask

  initial begin
    set_vec(0,  "wr_led_gated",   1'b0, 1'b1, ADDR_LED,    32'h0000_0ABC, 32'h0,   12'h000);
    set_vec(1,  "rd_led_zero",    1'b1, 1'b0, ADDR_LED,    32'h0,         32'h0,   12'h000);
    set_vec(2,  "wr_status",      1'b0, 1'b1, ADDR_STATUS, 32'hFFFF_FFFF, 32'h0,   12'h000);
    set_vec(3,  "wr_switch",      1'b0, 1'b1, ADDR_SWITCH, 32'hFFFF_FFFF, 32'h0,   12'h000);
    set_vec(4,  "wr_rsvd",        1'b0, 1'b1, ADDR_RSVD,   32'hFFFF_FFFF, 32'h0,   12'h000);
    set_vec(5,  "rd_rsvd",        1'b1, 1'b0, ADDR_RSVD,   32'h0,         32'h0,   12'h000);
    set_vec(6,  "wr_status_rdy",  1'b0, 1'b1, ADDR_STATUS, 32'h0,         32'h0,   12'h000);
    set_vec(7,  "rd_status_rdy",  1'b1, 1'b0, ADDR_STATUS, 32'h0,         32'h2,   12'h000);
    set_vec(8,  "wr_led_ok",      1'b0, 1'b1, ADDR_LED,    32'hFFFF_F123, 32'h0,   12'h123);
    set_vec(9,  "rd_led",         1'b1, 1'b0, ADDR_LED,    32'h0,         32'h123, 12'h123);
    set_vec(10, "rd_status_clr",  1'b1, 1'b0, ADDR_STATUS, 32'h0,         32'h0,   12'h123);
    set_vec(11, "wr_led_dropped", 1'b0, 1'b1, ADDR_LED,    32'h0000_0456, 32'h0,   12'h123);
    set_vec(12, "rd_led_again",   1'b1, 1'b0, ADDR_LED,    32'h0,         32'h123, 12'h123);
    set_vec(13, "rd_no_pread",    1'b0, 1'b0, ADDR_LED,    32'h0,         32'h0,   12'h123);

    reset = 1'b0; pRead = 1'b0; pWrite = 1'b0; addr = 2'b00; writeData = '0;
    btnL = 1'b0; btnR = 1'b0; switch = 16'hFFFF;

    // Reset held with buttons toggling.
    for (int i = 0; i < 6; i++) begin
      btnL = ~btnL;
      btnR = ~btnR;
      tick(1);
    end
    check("reset_led", {20'b0, led}, 32'h0);
    do_read("reset_status", ADDR_STATUS, 32'h0);
    do_read("reset_switch", ADDR_SWITCH, 32'h0);
    do_read("reset_led_rd", ADDR_LED, 32'h0);
    btnL = 1'b0; btnR = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(3);
    do_read("post_reset_status", ADDR_STATUS, 32'h0);

    // Capture: event lands on the 6th edge after the press.
    switch = 16'hA5C3;
    btnR   = 1'b1;
    tick(5);
    do_read("cap_not_early", ADDR_STATUS, 32'h0);
    tick(1);
    do_read("cap_ready", ADDR_STATUS, 32'h1);
    tick(2);
    btnR = 1'b0;
    do_read("cap_status_before", ADDR_STATUS, 32'h1);
    do_read("cap_switch", ADDR_SWITCH, 32'h0000_A5C3);
    tick(1);
    do_read("cap_status_after", ADDR_STATUS, 32'h0);
    tick(8);

    // Bounce: 2-cycle pulses never survive the stability window.
    switch = 16'h1234;
    for (int i = 0; i < 10; i++) begin
      btnR = (i % 2 == 0);
      tick(2);
    end
    btnR = 1'b0;
    tick(10);
    do_read("bounce_status", ADDR_STATUS, 32'h0);
    do_read("bounce_latch", ADDR_SWITCH, 32'h0000_A5C3);
    tick(1);

    // LED gating, table driven; btnL press inserted before vector 6.
    for (int i = 0; i < NVEC; i++) begin
      if (i == 6) begin
        btnL = 1'b1;
        tick(6);
        btnL = 1'b0;
        do_read("btnl_led_ready", ADDR_STATUS, 32'h2);
        tick(1);
      end
      pRead     = vecs[i].pread;
      pWrite    = vecs[i].pwrite;
      addr      = vecs[i].a;
      writeData = vecs[i].wdata;
      sb_q.push_back('{vecs[i].name, vecs[i].exp_rd});
      drain_sb();
      tick(1);
      check({vecs[i].name, "_led"}, {20'b0, led}, {20'b0, vecs[i].exp_led});
    end
    tick(8);

    // btnR event coincides with a SWITCH read: event wins.
    switch = 16'h1111;
    btnR   = 1'b1;
    tick(5);
    switch = 16'h5A5A;
    do_read("sim_read_old", ADDR_SWITCH, 32'h0000_A5C3);
    tick(1);
    do_read("sim_ready_kept", ADDR_STATUS, 32'h1);
    do_read("sim_new_latch", ADDR_SWITCH, 32'h0000_5A5A);
    btnR = 1'b0;
    tick(1);
    do_read("sim_cleared", ADDR_STATUS, 32'h0);
    tick(8);

    // Reset in the middle of a debounce window.
    btnR = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);
    check("rmid_led", {20'b0, led}, 32'h0);
    do_read("rmid_status_in_reset", ADDR_STATUS, 32'h0);
    reset = 1'b1;
    do_read("rmid_latch_cleared", ADDR_SWITCH, 32'h0);
    tick(5);
    do_read("rmid_not_early", ADDR_STATUS, 32'h0);
    tick(1);
    do_read("rmid_event", ADDR_STATUS, 32'h1);
    do_read("rmid_latch", ADDR_SWITCH, 32'h0000_5A5A);
    tick(1);
    do_read("rmid_cleared", ADDR_STATUS, 32'h0);
    tick(12);
    do_read("rmid_single_event", ADDR_STATUS, 32'h0);
    btnR = 1'b0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mmio_io_responder.md
Name: mmio_io_responder

Overview:
- Memory-mapped I/O responder on the peripheral side of the data-memory address decoder. It answers CPU loads and stores in the I/O window (addr[7]=1), selecting a register by word offset addr[3:2].
- Debounces the two push-buttons and latches the 16-bit switch bank on a debounced btnR press. Holds the 12-bit LED output register, which is armed by a debounced btnL press.
- Provides ready/status flags with clear-on-access semantics, so software can poll for input.

Parameters:
- DEBOUNCE_CYCLES, 16'd50000, consecutive stable samples required before a button level is accepted (must be >= 2).
- CNT_W, 16, width of the debounce counters; DEBOUNCE_CYCLES must fit in it.

Ports:
- clk  input  1  I/O clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- pRead  input  1  read select: the CPU access targets the I/O window.
- pWrite  input  1  qualified write strobe (writeEN AND I/O select); one cycle per store.
- addr  input  2  word offset (CPU addr[3:2]).
- writeData  input  32  store data.
- readData  output  32  load data, combinational from addr.
- btnL  input  1  raw push-button: LED-ready request.
- btnR  input  1  raw push-button: switch-capture request.
- switch  input  16  raw switch bank.
- led  output  12  LED register value.

Behaviour:
- Register map (addr):
  - 00: STATUS, read-only. Bit0 = sw_ready, bit1 = led_ready, bits[31:2] = 0.
  - 01: SWITCH, read-only. {16'b0, sw_latch}.
  - 10: LED, read/write. {20'b0, led}.
  - 11: reserved. Reads 0; writes ignored.
- Debounce, one instance per button:
  - 2-flop synchroniser, then a counter.
  - The counter increments while the synchronised level differs from the accepted level and clears otherwise.
  - When the count reaches DEBOUNCE_CYCLES-1, the accepted level flips and the counter clears.
  - Press event = one-cycle pulse on an accepted 0->1 transition.
  - Press-to-pulse latency = 2 + DEBOUNCE_CYCLES cycles.
- btnR press event:
  - sw_latch <= switch (raw sample taken in the same cycle).
  - sw_ready <= 1.
- Read of SWITCH:
  - Any cycle with pRead=1, pWrite=0, addr=01 clears sw_ready at the next edge.
  - readData shows the current sw_latch in that same cycle.
  - If a btnR event occurs in the same cycle, the event wins: sw_ready stays 1 and sw_latch updates.
- btnL press event: led_ready <= 1.
- Write to LED (pWrite=1, addr=10):
  - Takes effect only when led_ready=1. Then led <= writeData[11:0] and led_ready <= 0 at the next edge.
  - When led_ready=0 the write is dropped; led is unchanged.
  - A btnL event in the same cycle as an accepted write leaves led_ready=1 and led updated.
- Writes to STATUS, SWITCH or reserved have no effect.
- pRead=0: readData = 0.
- Reset (asynchronous, active-low):
  - led=0, sw_latch=0, sw_ready=0, led_ready=0.
  - Synchronisers, accepted levels and counters all = 0.
  - Reset asserted mid-debounce discards the partial count; no event is generated on release unless the button is still held for the full debounce period.
- Status reads have no side effects. A button held down produces exactly one event; the next event requires a debounced release first.

Decomposition:
- Package mmio_io_pkg:
  - Address offset localparams: ADDR_STATUS=2'b00, ADDR_SWITCH=2'b01, ADDR_LED=2'b10.
  - Status bit indices: SW_READY_BIT=0, LED_READY_BIT=1.
  - Default DEBOUNCE_CYCLES.
- One sub-module, btn_debounce:
  - Inputs: clk, reset, raw.
  - Outputs: level, press pulse.
  - Parameters: DEBOUNCE_CYCLES, CNT_W.
  - Instantiated twice.
- Top-level holds the register file and the read mux.

Test Plan (bench uses DEBOUNCE_CYCLES=4):
- Reset: hold reset=0 with switch=16'hFFFF and buttons toggling -> led=0; STATUS read = 32'h0; SWITCH read = 0.
- Capture: switch=16'hA5C3, btnR high 8 cycles -> sw_ready=1 exactly 6 cycles after press. SWITCH read = 32'h0000A5C3; STATUS reads 32'h1 before the SWITCH read and 32'h0 after it.
- Bounce: btnR toggled every 2 cycles for 20 cycles, then low -> no event; sw_ready stays 0; sw_latch unchanged.
- LED gating:
  - Write 32'h0000_0ABC to LED with led_ready=0 -> led stays 0.
  - Press btnL, then write 32'hFFFF_F123 -> led=12'h123, led_ready=0, LED read = 32'h123.
- Simultaneous: btnR event coincides with a SWITCH read -> sw_ready remains 1 and the new switch value is latched.
- Reset mid-debounce: btnR high 3 cycles, reset pulse, btnR stays high 10 more cycles -> exactly one event, occurring 6 cycles after reset release.
